// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage of the 8-bit computer. Holds the
//               fetch program counter and fetches instruction words from
//               instruction memory over a req/ack handshake. It presents one
//               instruction at a time to decode/execute using valid/ready
//               flow control. Redirects (jal, jr, taken beq) reload the fetch
//               PC, and any fetch made stale by a redirect is drained and
//               discarded.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               imem_req/addr      - fetch request and address (held to ack)
//               imem_ack/data      - memory response and instruction word
//               instr_out, opcode  - instruction register and its top nibble
//               instr_valid/ready  - handshake toward decode/execute
//               pc_out, pc_plus1   - address of IR instruction and its link
//               redirect(_pc)      - load a new fetch PC
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int PC_W = 8,
    parameter int IW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_data,
    output logic [IW-1:0]   instr_out,
    output logic [3:0]      opcode,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus1,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] drain_addr_q, drain_addr_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= '0;
            drain_addr_q <= '0;
            ir_q         <= '0;
            pc_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            ir_q         <= ir_d;
            pc_out_q     <= pc_out_d;
        end
    end

    // Redirect always takes priority over both imem_ack and instr_ready.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        ir_d         = ir_q;
        pc_out_d     = pc_out_q;
        imem_req     = 1'b0;
        imem_addr    = '0;
        instr_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) fetch_pc_d = redirect_pc;
            end

            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = fetch_pc_q;
                if (imem_ack && redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (imem_ack) begin
                    ir_d       = imem_data;
                    pc_out_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + c_PC_ONE;
                    state_d    = VALID;
                end else if (redirect) begin
                    // The request cannot be withdrawn: remember its address so
                    // it stays on imem_addr until the stale response arrives.
                    drain_addr_d = fetch_pc_q;
                    fetch_pc_d   = redirect_pc;
                    state_d      = DRAIN;
                end
            end

            VALID: begin
                instr_valid = 1'b1;
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = FETCH;
                end else if (instr_ready) begin
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (redirect) fetch_pc_d = redirect_pc;
                if (imem_ack) state_d = FETCH;
            end

            default: state_d = IDLE;
        endcase
    end

    assign instr_out = ir_q;
    assign opcode    = ir_q[IW-1 -: 4];
    assign pc_out    = pc_out_q;
    assign pc_plus1  = pc_out_q + c_PC_ONE;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit computer, directly upstream of the control decoder. Holds the program counter, fetches 8-bit instruction words from instruction memory over a req/ack handshake, and presents one instruction at a time to the decode/execute stage with valid/ready flow control. Accepts PC redirects for jal, jr and taken beq, and discards any fetch made stale by a redirect.

## Interface
- PC_W, 8, program counter and instruction-memory address width
- IW, 8, instruction word width; opcode is instr_out[IW-1:IW-4]
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  PC_W  fetch address; stable while imem_req high
- imem_ack  in  1  memory response valid this cycle; only meaningful while imem_req high
- imem_data  in  IW  instruction word, sampled when imem_ack high
- instr_out  out  IW  instruction register (IR)
- opcode  out  4  IR[IW-1:IW-4], feeds decoder instr input
- instr_valid  out  1  IR holds a live instruction
- instr_ready  in  1  downstream accepts IR this cycle
- pc_out  out  PC_W  address of the instruction in IR
- pc_plus1  out  PC_W  pc_out+1 mod 2^PC_W, jal link value
- redirect  in  1  load new fetch PC (jump, jr, taken beq)
- redirect_pc  in  PC_W  target address

## Operation
- Registers: fetch_pc, drain_addr, IR, pc_out, state (IDLE, FETCH, VALID, DRAIN).
- Reset (async, immediate): state=IDLE, fetch_pc=0, drain_addr=0, IR=0, pc_out=0, instr_valid=0, imem_req=0, imem_addr=0.
- IDLE: imem_req=0. Next edge -> FETCH (fetch_pc = redirect_pc if redirect).
- FETCH: imem_req=1, imem_addr=fetch_pc.
  - ack, no redirect: IR<=imem_data, pc_out<=fetch_pc, fetch_pc<=fetch_pc+1 (wraps 0xFF->0x00), -> VALID.
  - ack and redirect: data discarded, fetch_pc<=redirect_pc, -> FETCH.
  - no ack, redirect: drain_addr<=fetch_pc, fetch_pc<=redirect_pc, -> DRAIN.
  - no ack, no redirect: stay.
- VALID: instr_valid=1, imem_req=0, IR/pc_out held.
  - redirect (any instr_ready): IR discarded, fetch_pc<=redirect_pc, -> FETCH.
  - instr_ready, no redirect: consumed, -> FETCH.
  - else hold.
- DRAIN: imem_req=1, imem_addr=drain_addr (request is never withdrawn).
  - ack: data discarded, -> FETCH (fetch_pc<=redirect_pc if redirect same cycle).
  - redirect without ack: fetch_pc<=redirect_pc (newest wins), stay.
- instr_valid is 1 only in VALID. IR content after leaving VALID is don't-care for consumers but retains last value.
- pc_plus1 combinational from pc_out, modulo 2^PC_W.
- Redirect always beats instr_ready and imem_ack; a discarded word never reaches IR.

## Timing
- Fetch latency: ack in FETCH at edge N -> instr_valid high from N to consumption; ack may come in the first FETCH cycle (zero-wait memory).
- Throughput: max one instruction per 2 cycles (FETCH + VALID).
- First imem_req: cycle after the first edge following rst deassertion.
- Redirect to first req at new target: 1 cycle from VALID/FETCH-with-ack; from DRAIN, 1 cycle after the stale ack.
- imem_addr never changes while imem_req high without an intervening ack.
- rst mid-transaction: req drops immediately; an outstanding memory response is ignored after reset.

## Test plan
- Reset: assert rst mid-FETCH -> imem_req=0, instr_valid=0, pc_out=0, IR=0 within same cycle; after release, first req at addr 0x00.
- Straight line, zero-wait memory, instr_ready=1: mem[0..2]=0x8A,0x91,0x0C -> IR sequence 0x8A,0x91,0x0C, opcode 8,9,0, pc_out 0,1,2, valid every other cycle.
- Backpressure + latency: ack delayed 3 cycles, instr_ready low 4 cycles -> imem_addr stable during wait; IR/pc_out held, no new req until accepted.
- Redirect in VALID: IR=0xD3 at pc 0x05, redirect_pc=0x40 with instr_ready=1 -> instr_valid drops, next req addr 0x40, pc_plus1 was 0x06.
- Redirect during outstanding fetch: req at 0x10 unacked, redirect to 0x20, then second redirect to 0x30 before ack -> req stays at 0x10 until ack, data discarded, next req 0x30.
- Wrap: fetch at 0xFF -> pc_out=0xFF, pc_plus1=0x00, next req addr 0x00.
